// File: rtl/switch_allocator_pkg.sv
// Shared types and index helpers for the NoC switch allocator.
package noc_switch_pkg;

  // Per-requester FSM state.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    GRANT = 2'd2,
    HELD  = 2'd3
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Field width that never collapses to zero bits.
  function automatic int widthOf(input int n);
    return (clog2(n) > 1) ? clog2(n) : 1;
  endfunction

  // Requester (i,v) position in the flattened request buses.
  function automatic int reqIdx(input int i, input int v, input int vcN);
    return i * vcN + v;
  endfunction

  // Resource (o,v) position in the flattened resource buses.
  function automatic int resIdx(input int o, input int v, input int vcN);
    return o * vcN + v;
  endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// Request/response bundle between the input ports and the switch allocator.
// The tail-release strobe is pkt_release because "release" is a reserved word.
interface switch_allocator_if #(
  parameter int INPUTS  = 4,
  parameter int OUTPUTS = 4,
  parameter int VC      = 4
);
  localparam int DEST_W = noc_switch_pkg::widthOf(OUTPUTS);
  localparam int SEL_W  = noc_switch_pkg::widthOf(INPUTS);
  localparam int VC_W   = noc_switch_pkg::widthOf(VC);

  logic [VC_W-1:0]                vc_sel;
  logic [INPUTS*VC-1:0]           req_valid;
  logic [INPUTS*VC*DEST_W-1:0]    req_dest;
  logic [INPUTS*VC-1:0]           pkt_release;
  logic [INPUTS*VC-1:0]           grant;
  logic [INPUTS*VC-1:0]           reserved;
  logic [INPUTS*VC-1:0]           dest_err;
  logic [OUTPUTS*SEL_W-1:0]       route_select;
  logic [OUTPUTS-1:0]             output_busy;
  logic [OUTPUTS*VC-1:0]          busy_all;

  modport master (
    output vc_sel, req_valid, req_dest, pkt_release,
    input  grant, reserved, dest_err, route_select, output_busy, busy_all
  );

  modport slave (
    input  vc_sel, req_valid, req_dest, pkt_release,
    output grant, reserved, dest_err, route_select, output_busy, busy_all
  );
endinterface

// File: rtl/switch_allocator_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr wins, wrapping.
module rr_arbiter
  import noc_switch_pkg::*;
#(
  parameter int N = 4,
  localparam int W = widthOf(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);

  // Scan N slots starting at ptr and keep the first hit.
  always_comb begin : scan
    logic found;
    int   j;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = W'(j);
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// VC-aware switch allocator: one round-robin arbiter per (output, plane)
// resource, ownership held from grant until the holder's release.
module switch_allocator
  import noc_switch_pkg::*;
#(
  parameter int INPUTS  = 4,
  parameter int OUTPUTS = 4,
  parameter int VC      = 4,
  localparam int DEST_W = widthOf(OUTPUTS),
  localparam int SEL_W  = widthOf(INPUTS)
) (
  input logic clk,
  input logic rst,
  switch_allocator_if.slave bus
);

  localparam int NR   = INPUTS * VC;
  localparam int NRES = OUTPUTS * VC;

  state_e                         st [NR];
  logic [NR-1:0]                  destErr;
  logic [NR-1:0]                  destOk;
  logic [NR-1:0]                  winHit;
  logic [NRES-1:0]                busy;
  logic [NRES-1:0]                ownerRel;
  logic [NRES-1:0]                win;
  logic [NRES-1:0][SEL_W-1:0]     owner;
  logic [NRES-1:0][SEL_W-1:0]     ptr;
  logic [NRES-1:0][SEL_W-1:0]     arbIdx;
  logic [NRES-1:0][INPUTS-1:0]    arbReq;
  logic [NRES-1:0][INPUTS-1:0]    arbGnt;

  // Build per-resource request vectors and decide which resources can hand out a grant.
  always_comb begin : decode
    int r, k, oi;
    destOk   = '0;
    arbReq   = '0;
    ownerRel = '0;
    win      = '0;
    r = 0; k = 0; oi = 0;
    for (int n = 0; n < NR; n++)
      destOk[n] = int'(bus.req_dest[n*DEST_W +: DEST_W]) < OUTPUTS;
    for (int o = 0; o < OUTPUTS; o++) begin
      for (int v = 0; v < VC; v++) begin
        r = resIdx(o, v, VC);
        for (int i = 0; i < INPUTS; i++) begin
          k = reqIdx(i, v, VC);
          arbReq[r][i] = (st[k] == WAIT) && bus.req_valid[k] &&
                         (int'(bus.req_dest[k*DEST_W +: DEST_W]) == o);
        end
        // Owner's release in HELD frees the resource in the same cycle (bypass).
        oi = reqIdx(int'(owner[r]), v, VC);
        ownerRel[r] = busy[r] && (st[oi] == HELD) && bus.pkt_release[oi];
        win[r]      = (!busy[r] || ownerRel[r]) && (|arbReq[r]);
      end
    end
  end

  for (genvar g = 0; g < NRES; g++) begin : gArb
    rr_arbiter #(.N(INPUTS)) uArb (
      .req (arbReq[g]),
      .ptr (ptr[g]),
      .gnt (arbGnt[g]),
      .idx (arbIdx[g])
    );
  end

  // Fold arbiter winners back onto requesters.
  always_comb begin : fold
    winHit = '0;
    for (int o = 0; o < OUTPUTS; o++)
      for (int v = 0; v < VC; v++)
        for (int i = 0; i < INPUTS; i++)
          winHit[reqIdx(i, v, VC)] = winHit[reqIdx(i, v, VC)] |
                                     (win[resIdx(o, v, VC)] & arbGnt[resIdx(o, v, VC)][i]);
  end

  // Requester FSMs plus the registered bad-destination pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NR; k++) st[k] <= IDLE;
      destErr <= '0;
    end else begin
      for (int k = 0; k < NR; k++) begin
        destErr[k] <= 1'b0;
        case (st[k])
          IDLE:    if (bus.req_valid[k]) begin
                     if (destOk[k]) st[k] <= WAIT;
                     else           destErr[k] <= 1'b1;
                   end
          WAIT:    if (!bus.req_valid[k]) st[k] <= IDLE;
                   else if (winHit[k])    st[k] <= GRANT;
          GRANT:   st[k] <= HELD;
          HELD:    if (bus.pkt_release[k]) st[k] <= IDLE;
          default: st[k] <= IDLE;
        endcase
      end
    end
  end

  // Resource ownership, busy flags and round-robin pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy  <= '0;
      owner <= '0;
      ptr   <= '0;
    end else begin
      for (int r = 0; r < NRES; r++) begin
        if (win[r]) begin
          busy[r]  <= 1'b1;
          owner[r] <= arbIdx[r];
          ptr[r]   <= (int'(arbIdx[r]) == INPUTS - 1) ? '0 : arbIdx[r] + SEL_W'(1);
        end else if (ownerRel[r]) begin
          busy[r] <= 1'b0;
        end
      end
    end
  end

  assign bus.dest_err = destErr;
  assign bus.busy_all = busy;

  // State decode and the vc_sel crossbar view.
  always_comb begin : outs
    int vs;
    bus.grant        = '0;
    bus.reserved     = '0;
    bus.route_select = '0;
    bus.output_busy  = '0;
    vs = (int'(bus.vc_sel) < VC) ? int'(bus.vc_sel) : 0;
    for (int k = 0; k < NR; k++) begin
      bus.grant[k]    = (st[k] == GRANT);
      bus.reserved[k] = (st[k] == GRANT) || (st[k] == HELD);
    end
    for (int o = 0; o < OUTPUTS; o++) begin
      bus.route_select[o*SEL_W +: SEL_W] = owner[resIdx(o, vs, VC)];
      bus.output_busy[o]                 = busy[resIdx(o, vs, VC)];
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run, all compared each cycle against a behavioural model.
module tb_switch_allocator;

  localparam int NI = 4, NO = 5, NV = 4;
  localparam int DW = 3, SW = 2;
  localparam int NR = NI * NV, NRES = NO * NV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  switch_allocator_if #(.INPUTS(NI), .OUTPUTS(NO), .VC(NV)) bus ();

  switch_allocator #(.INPUTS(NI), .OUTPUTS(NO), .VC(NV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  bit chkOn = 1'b0;

  // Model: 0 idle, 1 waiting, 2 granted, 3 holding.
  int mSt [NR];
  bit mErr [NR];
  bit mBusy [NRES];
  int mOwner [NRES];
  int mPtr [NRES];

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, a, e, $time);
    end
  endtask

  function automatic int dst(input int k);
    return int'(bus.req_dest[k*DW +: DW]);
  endfunction

  // Behavioural model advanced on every clock edge.
  always @(posedge clk or negedge rst) begin : model
    bit win [NR];
    int w, i, k, r, ow;
    bit byp;
    if (!rst) begin
      for (int n = 0; n < NR; n++) begin mSt[n] = 0; mErr[n] = 0; end
      for (int n = 0; n < NRES; n++) begin mBusy[n] = 0; mOwner[n] = 0; mPtr[n] = 0; end
    end else begin
      for (int n = 0; n < NR; n++) win[n] = 0;
      for (int o = 0; o < NO; o++) begin
        for (int v = 0; v < NV; v++) begin
          r   = o * NV + v;
          ow  = mOwner[r] * NV + v;
          byp = mBusy[r] && mSt[ow] == 3 && bus.pkt_release[ow];
          if (!mBusy[r] || byp) begin
            w = -1;
            for (int s = 0; s < NI; s++) begin
              i = (mPtr[r] + s) % NI;
              k = i * NV + v;
              if (w < 0 && mSt[k] == 1 && bus.req_valid[k] && dst(k) == o) w = i;
            end
            if (w >= 0) begin
              win[w*NV+v] = 1; mOwner[r] = w; mBusy[r] = 1; mPtr[r] = (w + 1) % NI;
            end else if (byp) begin
              mBusy[r] = 0;
            end
          end
        end
      end
      for (int n = 0; n < NR; n++) begin
        mErr[n] = 0;
        case (mSt[n])
          0: if (bus.req_valid[n]) begin
               if (dst(n) < NO) mSt[n] = 1; else mErr[n] = 1;
             end
          1: if (!bus.req_valid[n]) mSt[n] = 0; else if (win[n]) mSt[n] = 2;
          2: mSt[n] = 3;
          default: if (bus.pkt_release[n]) mSt[n] = 0;
        endcase
      end
    end
  end

  // Compare every output against the model on the falling edge.
  always @(negedge clk) begin : cmp
    logic [NR-1:0] eG, eR, eE;
    logic [NRES-1:0] eB;
    logic [NO*SW-1:0] eRs;
    logic [NO-1:0] eOb;
    int vs, cnt;
    bit multi;
    if (chkOn) begin
      vs = int'(bus.vc_sel);
      for (int n = 0; n < NR; n++) begin
        eG[n] = (mSt[n] == 2);
        eR[n] = (mSt[n] >= 2);
        eE[n] = mErr[n];
      end
      for (int n = 0; n < NRES; n++) eB[n] = mBusy[n];
      for (int o = 0; o < NO; o++) begin
        eRs[o*SW +: SW] = SW'(mOwner[o*NV+vs]);
        eOb[o]          = mBusy[o*NV+vs];
      end
      chk("grant", 64'(bus.grant), 64'(eG));
      chk("reserved", 64'(bus.reserved), 64'(eR));
      chk("dest_err", 64'(bus.dest_err), 64'(eE));
      chk("busy_all", 64'(bus.busy_all), 64'(eB));
      chk("route_select", 64'(bus.route_select), 64'(eRs));
      chk("output_busy", 64'(bus.output_busy), 64'(eOb));
      multi = 0;
      for (int o = 0; o < NO; o++)
        for (int v = 0; v < NV; v++) begin
          cnt = 0;
          for (int i = 0; i < NI; i++)
            if (bus.grant[i*NV+v] && dst(i*NV+v) == o) cnt++;
          if (cnt > 1) multi = 1;
        end
      chk("one_grant_per_resource", 64'(multi), 64'(0));
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic setReq(input int i, input int v, input int d);
    bus.req_dest[(i*NV+v)*DW +: DW] = DW'(d);
    bus.req_valid[i*NV+v] = 1'b1;
  endtask

  task automatic dropReq(input int i, input int v);
    bus.req_valid[i*NV+v] = 1'b0;
  endtask

  task automatic setRel(input int i, input int v, input bit b);
    bus.pkt_release[i*NV+v] = b;
  endtask

  task automatic waitGrant(input int v, output int who);
    who = -1;
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < NI; i++) if (bus.grant[i*NV+v]) who = i;
      if (who >= 0) return;
      tick();
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : main
    int who;
    int order [4];
    bus.vc_sel = '0;
    bus.req_valid = '0;
    bus.req_dest = '0;
    bus.pkt_release = '0;
    #1 rst = 1'b0;
    #2 chkOn = 1'b1;
    chk("rst_grant", 64'(bus.grant), 64'(0));
    chk("rst_reserved", 64'(bus.reserved), 64'(0));
    chk("rst_busy_all", 64'(bus.busy_all), 64'(0));
    chk("rst_route", 64'(bus.route_select), 64'(0));
    #20 rst = 1'b1;
    tick();

    // Single request: input 1, plane 2, output 3.
    bus.vc_sel = 2'd2;
    setReq(1, 2, 3);
    tick();
    chk("t1_no_grant_cycle1", 64'(bus.grant), 64'(0));
    tick();
    chk("t1_grant", 64'(bus.grant), 64'h40);
    chk("t1_busy14", 64'(bus.busy_all[14]), 64'(1));
    chk("t1_route3", 64'(bus.route_select[3*SW +: SW]), 64'(1));
    dropReq(1, 2);
    tick();
    chk("t1_held", 64'(bus.reserved[6]), 64'(1));
    setRel(1, 2, 1'b1);
    tick();
    setRel(1, 2, 1'b0);
    chk("t1_freed", 64'(bus.busy_all[14]), 64'(0));

    // Conflict on (2,v0) among inputs 0,1,3; input 0 re-requests.
    bus.vc_sel = 2'd0;
    setReq(0, 0, 2); setReq(1, 0, 2); setReq(3, 0, 2);
    for (int n = 0; n < 4; n++) begin
      waitGrant(0, who);
      order[n] = who;
      if (who >= 0) begin
        dropReq(who, 0);
        tick(); tick();
        chk("t2_busy8", 64'(bus.busy_all[8]), 64'(1));
        setRel(who, 0, 1'b1);
        tick();
        setRel(who, 0, 1'b0);
        if (n == 0) setReq(0, 0, 2);
      end
    end
    chk("t2_order0", 64'(order[0]), 64'(0));
    chk("t2_order1", 64'(order[1]), 64'(1));
    chk("t2_order2", 64'(order[2]), 64'(3));
    chk("t2_order3", 64'(order[3]), 64'(0));

    // Release bypass on (1,v1): input 2 holds, input 0 waits.
    bus.vc_sel = 2'd1;
    setReq(2, 1, 1);
    tick(); tick();
    chk("t3_grant2", 64'(bus.grant[9]), 64'(1));
    dropReq(2, 1);
    setReq(0, 1, 1);
    tick(); tick();
    chk("t3_still_waiting", 64'(bus.grant[1]), 64'(0));
    setRel(2, 1, 1'b1);
    tick();
    setRel(2, 1, 1'b0);
    chk("t3_bypass_grant", 64'(bus.grant[1]), 64'(1));
    chk("t3_busy5", 64'(bus.busy_all[5]), 64'(1));
    chk("t3_route1", 64'(bus.route_select[1*SW +: SW]), 64'(0));
    dropReq(0, 1);
    tick();
    setRel(0, 1, 1'b1);
    tick();
    setRel(0, 1, 1'b0);

    // Plane isolation on output 2.
    setReq(0, 0, 2);
    tick(); tick();
    dropReq(0, 0);
    tick();
    setReq(1, 3, 2);
    tick(); tick();
    chk("t4_grant_v3", 64'(bus.grant[7]), 64'(1));
    dropReq(1, 3);
    bus.vc_sel = 2'd0;
    #1 chk("t4_ob_v0", 64'(bus.output_busy[2]), 64'(1));
    bus.vc_sel = 2'd3;
    #1 chk("t4_ob_v3", 64'(bus.output_busy[2]), 64'(1));
    tick();
    bus.vc_sel = 2'd1;
    #1 chk("t4_ob_v1", 64'(bus.output_busy[2]), 64'(0));
    setRel(0, 0, 1'b1); setRel(1, 3, 1'b1);
    tick();
    setRel(0, 0, 1'b0); setRel(1, 3, 1'b0);

    // Bad destination, then a withdrawn request.
    setReq(2, 0, 5);
    tick();
    dropReq(2, 0);
    chk("t5_dest_err", 64'(bus.dest_err), 64'h100);
    chk("t5_no_reserve", 64'(bus.reserved[8]), 64'(0));
    tick();
    chk("t5_err_once", 64'(bus.dest_err), 64'(0));
    setReq(3, 2, 4);
    tick();
    dropReq(3, 2);
    tick(); tick();
    chk("t5_withdraw_no_grant", 64'(bus.reserved[14]), 64'(0));
    chk("t5_withdraw_no_busy", 64'(bus.busy_all[18]), 64'(0));

    // Asynchronous reset while holding.
    setReq(1, 1, 0);
    tick(); tick();
    dropReq(1, 1);
    tick();
    chk("t6_held_before", 64'(bus.reserved[5]), 64'(1));
    #1 rst = 1'b0;
    #1;
    chk("t6_reserved0", 64'(bus.reserved), 64'(0));
    chk("t6_busy0", 64'(bus.busy_all), 64'(0));
    chk("t6_ob0", 64'(bus.output_busy), 64'(0));
    #2 rst = 1'b1;
    tick(); tick(); tick();
    chk("t6_quiet", 64'(bus.grant), 64'(0));

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      bus.vc_sel = 2'($urandom_range(0, NV - 1));
      for (int k = 0; k < NR; k++) begin
        if (!bus.req_valid[k]) begin
          if (mSt[k] == 0 && $urandom_range(0, 9) < 3) begin
            bus.req_dest[k*DW +: DW] = DW'($urandom_range(0, 6));
            bus.req_valid[k] = 1'b1;
          end
        end else if (mSt[k] != 1 || $urandom_range(0, 19) == 0) begin
          bus.req_valid[k] = 1'b0;
        end
        bus.pkt_release[k] = ($urandom_range(0, 3) == 0);
      end
      tick();
    end
    bus.req_valid = '0;
    bus.pkt_release = '0;
    tick(); tick();

    chkOn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
